// File: rtl/lsu_if.sv
// Request/response/data-memory bundle of the load/store unit.
// master = CPU side plus data_memory RD; slave = the unit itself.
interface lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_we;
  logic        mem_re;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  // Handshake: a request transfers on a posedge where req_valid and req_ready
  // are both 1; rsp_valid is a single-cycle pulse with no back-pressure.
  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rd,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_we, mem_re, mem_a, mem_wd
  );
  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rd,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_we, mem_re, mem_a, mem_wd
  );
endinterface

// File: rtl/load_store_unit.sv
// Byte/half/word load-store front end for data_memory with read-modify-write stores.
// Optional LSU_ERR_CNT_EN adds a saturating err_count output.
module load_store_unit #(
    parameter logic [31:0] MEM_BASE  = 32'h000003E0,
    parameter int          MEM_WORDS = 128
) (
    input  logic       clk,
    input  logic       rst,
    lsu_if.slave       bus,
    output logic [1:0] dbg_state_o
`ifdef LSU_ERR_CNT_EN
    ,
    output logic [15:0] err_count
`endif
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    localparam logic [32:0] MEM_END = {1'b0, MEM_BASE} + (33'(MEM_WORDS) * 33'd4);

    state_t      state_q, state_d;
    logic [31:0] addr_q, wdata_q, word_q, rdata_q;
    logic [1:0]  size_q;
    logic        uns_q, we_q, err_q;

    logic        req_err;
    logic [31:0] mem_a_w;
    logic [4:0]  sh;
    logic [15:0] rd_sh;
    logic [31:0] load_val;
    logic [31:0] lane_mask;
    logic [31:0] merged;

    always_comb begin
        req_err = 1'b0;
        if (bus.req_size == 2'b11) req_err = 1'b1;
        if (bus.req_size == 2'b01 && bus.req_addr[0]) req_err = 1'b1;
        if (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00) req_err = 1'b1;
        if (bus.req_addr < MEM_BASE) req_err = 1'b1;
        if ({1'b0, bus.req_addr} >= MEM_END) req_err = 1'b1;
    end

    // Lane handling: little-endian, byte lane selected by addr[1:0].
    assign mem_a_w   = MEM_BASE + ((addr_q - MEM_BASE) >> 2);
    assign sh        = {addr_q[1:0], 3'b000};
    assign rd_sh     = 16'(bus.mem_rd >> sh);
    assign lane_mask = (size_q == 2'b00) ? (32'h000000FF << sh) : (32'h0000FFFF << sh);
    assign merged    = (word_q & ~lane_mask) | ((wdata_q << sh) & lane_mask);

    always_comb begin
        load_val = bus.mem_rd;
        case (size_q)
            2'b00:   load_val = uns_q ? {24'b0, rd_sh[7:0]} : {{24{rd_sh[7]}}, rd_sh[7:0]};
            2'b01:   load_val = uns_q ? {16'b0, rd_sh} : {{16{rd_sh[15]}}, rd_sh};
            default: load_val = bus.mem_rd;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        bus.req_ready = 1'b0;
        bus.mem_re    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_a     = 32'h0;
        bus.mem_wd    = 32'h0;
        bus.rsp_valid = 1'b0;
        bus.rsp_rdata = 32'h0;
        bus.rsp_err   = 1'b0;
        case (state_q)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    if (req_err) state_d = RESP;
                    else if (bus.req_we && bus.req_size == 2'b10) state_d = WRITE;
                    else state_d = READ;
                end
            end
            READ: begin
                bus.mem_re = 1'b1;
                bus.mem_a  = mem_a_w;
                state_d    = we_q ? WRITE : RESP;
            end
            WRITE: begin
                bus.mem_we = 1'b1;
                bus.mem_a  = mem_a_w;
                bus.mem_wd = (size_q == 2'b10) ? wdata_q : merged;
                state_d    = RESP;
            end
            RESP: begin
                bus.rsp_valid = 1'b1;
                bus.rsp_rdata = rdata_q;
                bus.rsp_err   = err_q;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Async reset returns to IDLE at once, so mem_we falls before the write negedge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            word_q  <= 32'h0;
            rdata_q <= 32'h0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && bus.req_valid) begin
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
                size_q  <= bus.req_size;
                uns_q   <= bus.req_unsigned;
                we_q    <= bus.req_we;
                err_q   <= req_err;
                rdata_q <= 32'h0;
            end
            if (state_q == READ) begin
                word_q <= bus.mem_rd;
                if (!we_q) rdata_q <= load_val;
            end
        end
    end

    assign dbg_state_o = state_q;

`ifdef LSU_ERR_CNT_EN
    logic [15:0] err_cnt_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_cnt_q <= 16'h0;
        else if (state_q == RESP && err_q && err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'h1;
    end
    assign err_count = err_cnt_q;
`endif

endmodule
